seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's multi-digit 7-segment display. It owns a frame buffer of per-digit codes and character-mode flags. It steps one shared `bcd_7segment` decoder across all digits, driving its `bcd`/`c_flag` inputs and the active-low digit enables. New frames are loaded through a valid/ready handshake and committed only at a frame boundary, so a partially updated frame is never displayed.

## Interface
- `NUM_DIGITS`, 4: digits scanned; 2..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; >= 2.
- `DEAD`, 2: cycles at the start of each slot with all digits off (ghosting suppression); 0 <= DEAD < SCAN_DIV.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ld_valid`  in  1  frame load request.
- `ld_ready`  out  1  frame can be accepted.
- `ld_frame`  in  5*NUM_DIGITS  digit i at [5i+4:5i]: bit 5i+4 is c_flag, [5i+3:5i] is code.
- `blank`  in  1  force all digits off; scanning continues.
- `bcd`  out  4  code for the decoder.
- `c_flag`  out  1  character-mode select for the decoder.
- `digit_an`  out  NUM_DIGITS  digit enables, active-low, one-hot or all ones.
- `frame_tick`  out  1  one-cycle pulse on every scan wrap.

## Operation
- State:
  - `cnt`, prescale counter, 0..SCAN_DIV-1.
  - `idx`, digit index, 0..NUM_DIGITS-1.
  - `disp`, display frame.
  - `shadow`, accepted frame.
  - `pending` flag.
- `cnt` increments every cycle. At SCAN_DIV-1, `cnt` returns to 0 and `idx` advances. `idx` wraps from NUM_DIGITS-1 to 0.
- Wrap cycle: the cycle where cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1.
- Handshake:
  - `ld_ready` = !pending, registered.
  - Transfer occurs when ld_valid && ld_ready.
  - On transfer, ld_frame is copied to shadow and pending is set.
  - ld_frame is ignored without a transfer.
- Commit: on the wrap cycle with pending=1, shadow is copied to disp and pending is cleared.
  - A transfer and a commit never occur in the same cycle, because ld_ready is low while pending.
  - A frame accepted on a wrap cycle (pending was 0) commits at the next wrap, not the current one.
- Output generation, registered from the current state:
  - `digit_an` = all ones if blank or cnt < DEAD; otherwise ~(1<<idx).
  - `bcd`/`c_flag` = disp[idx].
  - `frame_tick` = 1 on the cycle after each wrap cycle, pending or not.
- Codes are passed through unmodified. Decoding, including the out-of-range '-' glyph, belongs to the decoder.
- Reset values:
  - cnt=0, idx=0, pending=0.
  - disp and shadow: every digit code 0 with c_flag=1 (blank glyph).
  - bcd=0, c_flag=1, digit_an=all ones, ld_ready=1, frame_tick=0.
- Reset mid-operation discards any pending frame and returns the display to blank glyphs on the next cycle.

## Timing
- State-to-output latency: 1 cycle.
- Frame period: NUM_DIGITS*SCAN_DIV cycles.
- Each digit is enabled for SCAN_DIV-DEAD cycles per frame.
- Load-to-visible latency runs from the transfer cycle to the commit wrap cycle, plus 1 cycle for digit 0 outputs: at most NUM_DIGITS*SCAN_DIV+1 cycles.
- ld_ready deasserts the cycle after a transfer and reasserts the cycle after commit.
- `blank` affects `digit_an` with 1-cycle latency. It never stalls cnt/idx or commit.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, DEAD=1.
- **Reset:** hold rst 2 cycles, then release -> bcd=0, c_flag=1, digit_an=1111, ld_ready=1, frame_tick=0 during reset. First enable digit_an=1110 appears 2 cycles after release.
- **Scan order:** run 32 cycles -> digit_an repeats (1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3). frame_tick pulses exactly every 16 cycles.
- **Load mid-frame:** load frame {d0=1, d1=2, d2=3, d3=4, all c_flag=0} while idx=1.
  - ld_ready=0 from the next cycle.
  - Outputs keep blank glyphs through the wrap; then bcd=1 with c_flag=0 on digit 0, then 2, 3, 4.
  - ld_ready=1 the cycle after commit.
- **Back-pressure:** hold ld_valid with a second frame (codes 9) while pending -> not accepted until ld_ready returns. It commits one full frame (16 cycles) after the first.
- **Load on wrap cycle:** accept a frame on the wrap cycle -> disp is unchanged for the following 16 cycles, then commits at the next wrap.
- **Blank and reset:**
  - blank=1 for 10 cycles mid-scan -> digit_an=1111 one cycle later. On release, scanning resumes at the idx implied by elapsed cycles.
  - rst asserted with pending=1 -> ld_ready=1 and blank glyphs after reset; the pending frame never appears.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a time-multiplexed multi-digit 7-segment display.
// Holds a double-buffered frame and steps one shared decoder across all digits.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [5*NUM_DIGITS-1:0] ld_frame,
  input  logic                    blank,
  output logic [3:0]              bcd,
  output logic                    c_flag,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  // Code 0 with c_flag set is the decoder's blank glyph.
  localparam logic [NUM_DIGITS-1:0][4:0] BLANK_FRAME = {NUM_DIGITS{5'b1_0000}};

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][4:0]   disp;
  logic [NUM_DIGITS-1:0][4:0]   shadow;
  logic                         pending;

  logic wrap;
  logic xfer;
  logic commit;
  logic pending_nxt;
  logic in_dead;

  assign wrap   = (cnt == CNT_MAX) && (idx == IDX_MAX);
  assign xfer   = ld_valid && ld_ready;
  // ld_ready is low whenever pending is set, so xfer and commit are exclusive.
  assign commit = wrap && pending;

  always_comb begin
    // NOTE: assign a default first in every always_comb so no path leaves the
    // variable unassigned, which would infer a latch.
    pending_nxt = pending;
    if (xfer) begin
      pending_nxt = 1'b1;
    end else if (commit) begin
      pending_nxt = 1'b0;
    end
  end

  if (DEAD == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt < CW'(DEAD));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      ld_ready   <= 1'b1;
      // NOTE: both frame buffers are reset on purpose: the display must show
      // blank glyphs right after reset, and a stale shadow must never commit.
      disp       <= BLANK_FRAME;
      shadow     <= BLANK_FRAME;
      bcd        <= 4'd0;
      c_flag     <= 1'b1;
      digit_an   <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (xfer) begin
        shadow <= ld_frame;
      end
      if (commit) begin
        disp <= shadow;
      end
      pending  <= pending_nxt;
      ld_ready <= !pending_nxt;

      // Outputs are one cycle behind the scan state they describe.
      frame_tick      <= wrap;
      {c_flag, bcd}   <= disp[idx];
      digit_an        <= (blank || in_dead) ? '1 : ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4, DEAD=1.
// One frame = 16 cycles; cycle n counts clock edges since reset release.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [19:0] ld_frame;
  logic        blank;
  logic [3:0]  bcd;
  logic        c_flag;
  logic [3:0]  digit_an;
  logic        frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .DEAD      (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_frame  (ld_frame),
    .blank     (blank),
    .bcd       (bcd),
    .c_flag    (c_flag),
    .digit_an  (digit_an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       blank;
    logic       ld_valid;
    logic [3:0] exp_an;
    logic       exp_tick;
  } vec_t;

  vec_t tbl[16];

  // Frames are written d3..d0, each digit {c_flag, code}.
  localparam logic [19:0] F_BLANK = {4{5'h10}};
  localparam logic [19:0] F1 = {5'h04, 5'h03, 5'h02, 5'h01};
  localparam logic [19:0] F2 = {4{5'h09}};
  localparam logic [19:0] F3 = {5'h05, 5'h1B, 5'h06, 5'h1A};
  localparam logic [19:0] F4 = {4{5'h03}};

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [19:0] shown;
  logic        ready_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one edge, then compare every output against the expected scan
  // pattern, the glyph of the digit in its slot, and the expected ld_ready.
  task automatic step();
    logic b;
    int   di;
    b = blank;
    @(posedge clk);
    #1;
    cyc++;
    di = ((cyc - 1) / 4) % 4;
    check("digit_an", 32'(digit_an), b ? 32'hF : 32'(tbl[(cyc - 1) % 16].exp_an));
    check("frame_tick", 32'(frame_tick), 32'(tbl[(cyc - 1) % 16].exp_tick));
    check("bcd", 32'(bcd), 32'(shown[di*5 +: 4]));
    check("c_flag", 32'(c_flag), 32'(shown[di*5 + 4]));
    check("ld_ready", 32'(ld_ready), 32'(ready_exp));
  endtask

  task automatic check_reset_state();
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_c_flag", 32'(c_flag), 32'h1);
    check("rst_digit_an", 32'(digit_an), 32'hF);
    check("rst_ld_ready", 32'(ld_ready), 32'h1);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 4'b1111, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b1110, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b1110, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b1110, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1101, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b1101, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b1101, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b1011, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'b1011, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b1011, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b1111, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0111, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0111, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'b0111, 1'b1};

    rst       = 1'b1;
    ld_valid  = 1'b0;
    ld_frame  = '0;
    blank     = 1'b0;
    shown     = F_BLANK;
    ready_exp = 1'b1;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    cyc = 0;

    // Two full frames of idle scanning straight from the table.
    for (int i = 0; i < 32; i++) begin
      blank    = tbl[i % 16].blank;
      ld_valid = tbl[i % 16].ld_valid;
      step();
    end

    // Mid-frame load, back-pressure, wrap-cycle load, blank window, then a
    // load left pending before a second reset.
    while (cyc < 133) begin
      case (cyc)
        36: begin ld_frame = F1; ld_valid = 1'b1; ready_exp = 1'b0; end
        37: ld_frame = F2;
        47: ready_exp = 1'b1;
        48: begin ready_exp = 1'b0; shown = F1; end
        49: ld_valid = 1'b0;
        63: ready_exp = 1'b1;
        64: shown = F2;
        79: begin ld_frame = F3; ld_valid = 1'b1; ready_exp = 1'b0; end
        80: ld_valid = 1'b0;
        95: ready_exp = 1'b1;
        96: shown = F3;
        113: blank = 1'b1;
        123: blank = 1'b0;
        129: begin ld_frame = F4; ld_valid = 1'b1; ready_exp = 1'b0; end
        130: ld_valid = 1'b0;
        default: ;
      endcase
      step();
    end

    // Reset while F4 is pending: it must be discarded.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cyc       = 0;
    shown     = F_BLANK;
    ready_exp = 1'b1;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
